rectangle128_ctrl: RTL and testbench

Sequencing controller for the RECTANGLE-128 engine. It restarts and enables the sub-key generator when a new 128-bit key is loaded, then gates block processing until all 26 round keys are in the round-key memory. For each accepted block it drives the round datapath: load, 25 rounds, final key addition. It reads round keys in forward order for encryption and reverse order for decryption. It sits between the host-side valid/ready streams and the skeygen / round-key memory / round datapath.

---
 rtl/rectangle128_pkg.sv | 42 ++++
 rtl/rectangle128_rk_addr_gen.sv | 61 ++++++
 rtl/rectangle128_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rectangle128_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rectangle128_pkg.sv
// rectangle128_pkg
// Shared constants and types for the RECTANGLE-128 sequencing logic.
//   ROUNDS     : number of full rounds; the key schedule holds ROUNDS+1 keys
//   NUM_RK     : number of round keys held in the round-key memory
//   KG_CYCLES  : enabled sub-key generator cycles from restart to last write
//   AW         : round-key memory address width
//   CW         : width of the key-generation and round counters
//   ctrl_state_e : controller state encoding, shared with datapath monitors
//   rk_index() : maps a forward round index to the memory address for the
//                requested direction
package rectangle128_pkg;

  localparam int ROUNDS    = 25;
  localparam int NUM_RK    = ROUNDS + 1;
  localparam int KG_CYCLES = 27;
  localparam int AW        = 5;
  localparam int CW        = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KRST  = 3'd1,
    ST_KGEN  = 3'd2,
    ST_READY = 3'd3,
    ST_RUN   = 3'd4,
    ST_FINAL = 3'd5,
    ST_OUT   = 3'd6
  } ctrl_state_e;

  // Decryption walks the key schedule backwards, so index i maps to
  // ROUNDS-i; encryption uses the index unchanged.
  function automatic logic [AW-1:0] rk_index(input logic dec,
                                             input logic [AW-1:0] idx);
    logic [AW-1:0] addr;
    if (dec) begin
      addr = AW'(ROUNDS) - idx;
    end else begin
      addr = idx;
    end
    return addr;
  endfunction

endpackage

// File: rtl/rectangle128_rk_addr_gen.sv
// rectangle128_rk_addr_gen
// Round counter plus forward/reverse round-key address generation.
// Kept separate so a decryption-only core can reuse the same sequencing.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : clear the round counter (block accepted)
//   run         : a full round is executing this cycle; counter advances
//   final_add   : the final key addition is executing this cycle
//   dec         : 1 = walk the key schedule in reverse order
//   last_round  : the round in progress is the last full round
//   raddr       : combinational round-key memory read address
module rectangle128_rk_addr_gen
  import rectangle128_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          run,
  input  logic          final_add,
  input  logic          dec,
  output logic          last_round,
  output logic [AW-1:0] raddr
);

  logic [CW-1:0] rnd_q;
  logic [CW-1:0] rnd_d;

  // The counter only moves while rounds execute, so it stops at ROUNDS
  // during the final addition and never wraps.
  always_comb begin
    rnd_d = rnd_q;
    if (start) begin
      rnd_d = '0;
    end else if (run) begin
      rnd_d = rnd_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign last_round = (rnd_q == CW'(ROUNDS - 1));

  // The final addition uses the key after the last round in the chosen
  // direction: index ROUNDS maps to address ROUNDS (encrypt) or 0 (decrypt).
  // The address is parked at 0 whenever the memory is not being read.
  always_comb begin
    raddr = '0;
    if (run) begin
      raddr = rk_index(dec, AW'(rnd_q));
    end else if (final_add) begin
      raddr = rk_index(dec, AW'(ROUNDS));
    end
  end

endmodule

// File: rtl/rectangle128_ctrl.sv
// rectangle128_ctrl
// Sequencing controller for the RECTANGLE-128 engine. A new key restarts
// and enables the sub-key generator; blocks are only accepted once all
// round keys are in memory. Each block is loaded, run through ROUNDS
// rounds, finished with a key addition and then held until consumed.
// Ports:
//   Clk, RstN           : clock and asynchronous active-low reset
//   key_valid/key_ready : key handshake; key0/key1 captured on handshake
//   kg_key0/kg_key1     : registered key presented to the sub-key generator
//   kg_rst_n, kg_en     : sub-key generator reset and enable
//   key_loaded          : every round key in memory is valid
//   din_valid/din_ready : block handshake; din_dec selects decryption
//   dp_load/dp_round/dp_final : datapath operation strobes
//   dp_dec              : direction of the block in flight
//   rk_raddr            : round-key memory read address
//   dout_valid/dout_ready : result handshake
module rectangle128_ctrl
  import rectangle128_pkg::*;
(
  input  logic          Clk,
  input  logic          RstN,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [63:0]   key0,
  input  logic [63:0]   key1,
  output logic [63:0]   kg_key0,
  output logic [63:0]   kg_key1,
  output logic          kg_rst_n,
  output logic          kg_en,
  output logic          key_loaded,
  input  logic          din_valid,
  input  logic          din_dec,
  output logic          din_ready,
  output logic          dp_load,
  output logic          dp_round,
  output logic          dp_final,
  output logic          dp_dec,
  output logic [AW-1:0] rk_raddr,
  output logic          dout_valid,
  input  logic          dout_ready
);

  ctrl_state_e   state_q;
  ctrl_state_e   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [63:0]   kg_key0_q;
  logic [63:0]   kg_key0_d;
  logic [63:0]   kg_key1_q;
  logic [63:0]   kg_key1_d;
  logic          key_loaded_q;
  logic          key_loaded_d;
  logic          dp_dec_q;
  logic          dp_dec_d;
  logic          kg_restart_q;
  logic          kg_restart_d;

  logic          key_ready_c;
  logic          accept_key;
  logic          rnd_start;
  logic          last_round;

  // Next-state and strobe logic. A key offered alongside a block in READY
  // takes priority, and din_ready is withdrawn in that cycle so the block
  // is never accepted against keys that are about to be replaced.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kg_key0_d    = kg_key0_q;
    kg_key1_d    = kg_key1_q;
    key_loaded_d = key_loaded_q;
    dp_dec_d     = dp_dec_q;
    key_ready_c  = 1'b0;
    accept_key   = 1'b0;
    din_ready    = 1'b0;
    dp_load      = 1'b0;
    kg_en        = 1'b0;
    dp_round     = 1'b0;
    dp_final     = 1'b0;
    dout_valid   = 1'b0;
    rnd_start    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        key_ready_c = 1'b1;
        accept_key  = key_valid;
      end
      ST_READY: begin
        key_ready_c = 1'b1;
        din_ready   = !key_valid;
        if (key_valid) begin
          accept_key = 1'b1;
        end else if (din_valid) begin
          dp_load   = 1'b1;
          dp_dec_d  = din_dec;
          rnd_start = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_KRST: begin
        cnt_d   = '0;
        state_d = ST_KGEN;
      end
      ST_KGEN: begin
        kg_en = 1'b1;
        if (cnt_q == CW'(KG_CYCLES - 1)) begin
          key_loaded_d = 1'b1;
          state_d      = ST_READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        dp_round = 1'b1;
        if (last_round) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        dp_final = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The old schedule is invalid as soon as a new key is taken.
    if (accept_key) begin
      kg_key0_d    = key0;
      kg_key1_d    = key1;
      key_loaded_d = 1'b0;
      state_d      = ST_KRST;
    end

    // Registering the restart keeps glitches off the generator's reset.
    kg_restart_d = (state_d == ST_KRST);
  end

  // State and captured-context registers.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      kg_key0_q    <= '0;
      kg_key1_q    <= '0;
      key_loaded_q <= 1'b0;
      dp_dec_q     <= 1'b0;
      kg_restart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kg_key0_q    <= kg_key0_d;
      kg_key1_q    <= kg_key1_d;
      key_loaded_q <= key_loaded_d;
      dp_dec_q     <= dp_dec_d;
      kg_restart_q <= kg_restart_d;
    end
  end

  rectangle128_rk_addr_gen u_rk_addr_gen (
    .clk        (Clk),
    .rst_n      (RstN),
    .start      (rnd_start),
    .run        (dp_round),
    .final_add  (dp_final),
    .dec        (dp_dec_q),
    .last_round (last_round),
    .raddr      (rk_raddr)
  );

  // key_ready is held low while reset is asserted so that every handshake
  // output is quiet during reset, even though IDLE would otherwise offer it.
  assign key_ready  = key_ready_c & RstN;
  assign kg_rst_n   = RstN & ~kg_restart_q;
  assign kg_key0    = kg_key0_q;
  assign kg_key1    = kg_key1_q;
  assign key_loaded = key_loaded_q;
  assign dp_dec     = dp_dec_q;

endmodule

// File: tb/tb_rectangle128_ctrl.sv
// tb_rectangle128_ctrl
// Self-checking bench for rectangle128_ctrl. A timeline model predicts
// every output from the cycle numbers of the key and block handshakes;
// a compare process checks all outputs on every falling edge. Directed
// scenarios pin the model with hand-computed literals, then randomized
// traffic (including occasional resets) runs against the model.
module tb_rectangle128_ctrl;

  localparam int NRND  = 25;
  localparam int KGLEN = 27;

  logic        Clk;
  logic        RstN;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key0;
  logic [63:0] key1;
  logic [63:0] kg_key0;
  logic [63:0] kg_key1;
  logic        kg_rst_n;
  logic        kg_en;
  logic        key_loaded;
  logic        din_valid;
  logic        din_dec;
  logic        din_ready;
  logic        dp_load;
  logic        dp_round;
  logic        dp_final;
  logic        dp_dec;
  logic [4:0]  rk_raddr;
  logic        dout_valid;
  logic        dout_ready;

  int tests = 0;
  int fails = 0;

  rectangle128_ctrl dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key0       (key0),
    .key1       (key1),
    .kg_key0    (kg_key0),
    .kg_key1    (kg_key1),
    .kg_rst_n   (kg_rst_n),
    .kg_en      (kg_en),
    .key_loaded (key_loaded),
    .din_valid  (din_valid),
    .din_dec    (din_dec),
    .din_ready  (din_ready),
    .dp_load    (dp_load),
    .dp_round   (dp_round),
    .dp_final   (dp_final),
    .dp_dec     (dp_dec),
    .rk_raddr   (rk_raddr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Timeline model: cycle n is the interval after rising edge n.
  int          m_cyc   = 0;
  int          m_key_t = -1;
  int          m_blk_t = -1;
  bit          m_kl    = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_dec   = 1'b0;
  logic [63:0] m_k0    = '0;
  logic [63:0] m_k1    = '0;

  function automatic bit m_krst();
    return RstN && (m_key_t >= 0) && (m_cyc == m_key_t);
  endfunction

  function automatic bit m_kgen();
    return RstN && (m_key_t >= 0) && (m_cyc >= m_key_t + 1) && (m_cyc <= m_key_t + KGLEN);
  endfunction

  function automatic bit m_keyprog();
    return (m_key_t >= 0) && (m_cyc <= m_key_t + KGLEN);
  endfunction

  function automatic bit m_ready();
    return RstN && m_kl && !m_busy;
  endfunction

  function automatic bit m_idle();
    return RstN && !m_kl && !m_keyprog();
  endfunction

  function automatic bit m_round();
    return RstN && m_busy && (m_cyc >= m_blk_t) && (m_cyc <= m_blk_t + NRND - 1);
  endfunction

  function automatic bit m_final();
    return RstN && m_busy && (m_cyc == m_blk_t + NRND);
  endfunction

  function automatic bit m_out();
    return RstN && m_busy && (m_cyc >= m_blk_t + NRND + 1);
  endfunction

  function automatic logic [4:0] m_raddr();
    int idx;
    idx = 0;
    if (m_round()) idx = m_dec ? (NRND - (m_cyc - m_blk_t)) : (m_cyc - m_blk_t);
    else if (m_final()) idx = m_dec ? 0 : NRND;
    return 5'(idx);
  endfunction

  task automatic model_reset();
    m_key_t = -1;
    m_blk_t = -1;
    m_kl    = 1'b0;
    m_busy  = 1'b0;
    m_dec   = 1'b0;
    m_k0    = '0;
    m_k1    = '0;
  endtask

  task automatic model_step();
    bit kr;
    bit dr;
    bit ov;
    kr = m_idle() || m_ready();
    dr = m_ready() && !key_valid;
    ov = m_out();
    if (kr && key_valid) begin
      m_key_t = m_cyc + 1;
      m_kl    = 1'b0;
      m_k0    = key0;
      m_k1    = key1;
    end else if (dr && din_valid) begin
      m_blk_t = m_cyc + 1;
      m_busy  = 1'b1;
      m_dec   = din_dec;
    end
    if (ov && dout_ready) m_busy = 1'b0;
    m_cyc++;
    if ((m_key_t >= 0) && (m_cyc == m_key_t + KGLEN + 1)) m_kl = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge Clk or negedge RstN);
      if (!RstN) model_reset();
      else model_step();
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge Clk);
      checkOutput("key_ready",  key_ready,  (m_idle() || m_ready()));
      checkOutput("din_ready",  din_ready,  (m_ready() && !key_valid));
      checkOutput("dp_load",    dp_load,    (m_ready() && !key_valid && din_valid));
      checkOutput("kg_rst_n",   kg_rst_n,   (RstN && !m_krst()));
      checkOutput("kg_en",      kg_en,      m_kgen());
      checkOutput("key_loaded", key_loaded, m_kl);
      checkOutput("kg_key0",    kg_key0,    m_k0);
      checkOutput("kg_key1",    kg_key1,    m_k1);
      checkOutput("dp_round",   dp_round,   m_round());
      checkOutput("dp_final",   dp_final,   m_final());
      checkOutput("dp_dec",     dp_dec,     m_dec);
      checkOutput("rk_raddr",   rk_raddr,   m_raddr());
      checkOutput("dout_valid", dout_valid, m_out());
    end
  end

  task automatic applyStimulus(input logic kv, input logic [63:0] k0, input logic [63:0] k1,
                               input logic dv, input logic dd, input logic dr);
    @(posedge Clk);
    #1;
    key_valid  = kv;
    key0       = k0;
    key1       = k1;
    din_valid  = dv;
    din_dec    = dd;
    dout_ready = dr;
  endtask

  task automatic wait_key_loaded(input string name);
    int w;
    w = 0;
    while (!key_loaded && w < 60) begin
      @(negedge Clk);
      w++;
    end
    checkOutput(name, key_loaded, 1'b1);
  endtask

  // One block with dout_ready high; the handshake edge is cycle 0 of the trace.
  task automatic run_block(input logic dec, output int rounds, output int sum,
                           output int first_addr, output int fin_addr, output int fin_at,
                           output int dv_cnt, output int dv_first, output int dec_cnt,
                           output int load_seen);
    rounds = 0; sum = 0; first_addr = -1; fin_addr = -1; fin_at = -1;
    dv_cnt = 0; dv_first = -1; dec_cnt = 0;
    applyStimulus(1'b0, '0, '0, 1'b1, dec, 1'b1);
    @(negedge Clk);
    load_seen = int'(dp_load);
    applyStimulus(1'b0, '0, '0, 1'b0, dec, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (dp_round) begin
        if (rounds == 0) first_addr = int'(rk_raddr);
        rounds++;
        sum += int'(rk_raddr);
        if (dp_dec) dec_cnt++;
      end
      if (dp_final) begin
        fin_addr = int'(rk_raddr);
        fin_at   = i;
      end
      if (dout_valid) begin
        if (dv_first < 0) dv_first = i;
        dv_cnt++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en_cnt, rl_cnt, kl_first, stall_ok, w;
    int rounds, sum, first_addr, fin_addr, fin_at, dv_cnt, dv_first, dec_cnt, load_seen;
    logic [63:0] ka, kb;

    RstN       = 1'b0;
    key_valid  = 1'b0;
    key0       = '0;
    key1       = '0;
    din_valid  = 1'b0;
    din_dec    = 1'b0;
    dout_ready = 1'b0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset_kg_rst_n",  kg_rst_n,  1'b0);
    checkOutput("reset_key_ready", key_ready, 1'b0);
    @(posedge Clk);
    #1 RstN = 1'b1;
    @(negedge Clk);
    checkOutput("idle_key_ready",  key_ready,  1'b1);
    checkOutput("idle_key_loaded", key_loaded, 1'b0);
    checkOutput("idle_raddr",      rk_raddr,   5'd0);

    // All-zero key: one restart cycle, 27 enables, keys valid 28 cycles later.
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    en_cnt = 0; rl_cnt = 0; kl_first = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (kg_en) en_cnt++;
      if (!kg_rst_n) rl_cnt++;
      if (key_loaded && kl_first < 0) kl_first = i;
    end
    checkOutput("kgen_enable_cycles",  64'(en_cnt),   64'd27);
    checkOutput("kgen_restart_cycles", 64'(rl_cnt),   64'd1);
    checkOutput("kgen_loaded_at",      64'(kl_first), 64'd28);
    checkOutput("kgen_din_ready",      din_ready,     1'b1);

    // Encrypt: addresses 0..24 (sum 300), final at 25, result at D+26.
    run_block(1'b0, rounds, sum, first_addr, fin_addr, fin_at, dv_cnt, dv_first, dec_cnt, load_seen);
    checkOutput("enc_dp_load",   64'(load_seen),  64'd1);
    checkOutput("enc_rounds",    64'(rounds),     64'd25);
    checkOutput("enc_addr_sum",  64'(sum),        64'd300);
    checkOutput("enc_first",     64'(first_addr), 64'd0);
    checkOutput("enc_final",     64'(fin_addr),   64'd25);
    checkOutput("enc_final_at",  64'(fin_at),     64'd25);
    checkOutput("enc_dout_cnt",  64'(dv_cnt),     64'd1);
    checkOutput("enc_dout_at",   64'(dv_first),   64'd26);
    checkOutput("enc_dec_cnt",   64'(dec_cnt),    64'd0);

    // Decrypt: addresses 25..1 (sum 325), final at 0.
    run_block(1'b1, rounds, sum, first_addr, fin_addr, fin_at, dv_cnt, dv_first, dec_cnt, load_seen);
    checkOutput("dec_rounds",    64'(rounds),     64'd25);
    checkOutput("dec_addr_sum",  64'(sum),        64'd325);
    checkOutput("dec_first",     64'(first_addr), 64'd25);
    checkOutput("dec_final",     64'(fin_addr),   64'd0);
    checkOutput("dec_dout_at",   64'(dv_first),   64'd26);
    checkOutput("dec_dec_cnt",   64'(dec_cnt),    64'd25);

    // Result held for 10 cycles while a key is offered and must be ignored.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (!dout_valid && w < 40) begin
      @(negedge Clk);
      w++;
    end
    checkOutput("stall_reach_out", dout_valid, 1'b1);
    stall_ok = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98, 1'b0, 1'b0, 1'b0);
      @(negedge Clk);
      if (dout_valid && !din_ready && !key_ready) stall_ok++;
    end
    checkOutput("stall_hold",     64'(stall_ok), 64'd10);
    checkOutput("stall_key_kept", kg_key0,       64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("stall_release_ready", din_ready, 1'b1);

    // Key and block offered together: the key wins.
    ka = 64'h0123_4567_89AB_CDEF;
    kb = 64'hFEDC_BA98_7654_3210;
    applyStimulus(1'b1, ka, kb, 1'b1, 1'b0, 1'b1);
    @(negedge Clk);
    checkOutput("both_din_ready", din_ready, 1'b0);
    checkOutput("both_dp_load",   dp_load,   1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    checkOutput("both_key_loaded_low", key_loaded, 1'b0);
    checkOutput("both_krst",           kg_rst_n,   1'b0);
    checkOutput("both_kg_key0",        kg_key0,    ka);
    wait_key_loaded("both_reload");

    // Reset asserted while round 12 is in progress.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (12) @(posedge Clk);
    #1 RstN = 1'b0;
    #1;
    checkOutput("mid_reset_round",  dp_round,   1'b0);
    checkOutput("mid_reset_raddr",  rk_raddr,   5'd0);
    checkOutput("mid_reset_loaded", key_loaded, 1'b0);
    checkOutput("mid_reset_kg_en",  kg_en,      1'b0);
    repeat (2) @(posedge Clk);
    #1 RstN = 1'b1;
    @(negedge Clk);
    checkOutput("post_reset_key_ready", key_ready, 1'b1);
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    applyStimulus(1'b1, ka, kb, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    wait_key_loaded("post_reset_reload");
    checkOutput("post_reset_kg_key1", kg_key1, kb);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        @(posedge Clk);
        #1 RstN = 1'b0;
        @(posedge Clk);
        #1 RstN = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 59) == 0, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) != 0);
      end
    end

    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
